// File: rtl/branch_ctrl.sv
// Branch resolution controller: stalls for operands, resolves, redirects fetch, counts branches.
// Latency: resolve in the cycle operands are ready; redirect_valid/flush exactly one cycle later.
// Backpressure: stall holds PC, IF/ID and ID/EX while a branch in EX waits for forwarded operands.
module branch_ctrl #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             br_valid,
  input  logic [2:0]       br_func3,
  input  logic             opnd_ready,
  input  logic [WIDTH-1:0] pc_ex,
  input  logic [WIDTH-1:0] imm_b,
  input  logic             BEQ,
  input  logic             BNE,
  input  logic             BLT,
  input  logic             BGE,
  output logic             BranchEn,
  output logic             stall,
  output logic             flush,
  output logic             redirect_valid,
  output logic [WIDTH-1:0] redirect_pc,
  output logic [CNT_W-1:0] br_count,
  output logic [CNT_W-1:0] taken_count
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'b00,
    ST_WAIT     = 2'b01,
    ST_REDIRECT = 2'b10
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};
  localparam logic [WIDTH-1:0] ALIGN_MASK = {{(WIDTH-1){1'b1}}, 1'b0};

  state_t state;
  state_t state_nxt;
  logic   active;
  logic   in_redirect;
  logic   func_ok;
  logic   resolve;
  logic   taken;

  // Output decode from the registered state; reset and illegal encodings force everything low
  always_comb begin
    active      = !reset && ((state == ST_IDLE) || (state == ST_WAIT));
    in_redirect = !reset && (state == ST_REDIRECT);
    // func3 codes with bit 1 set (010, 011, 110, 111) are not supported branches
    func_ok     = (br_func3[1] == 1'b0);
    resolve     = active && br_valid && opnd_ready;
    taken       = resolve && func_ok && (BEQ || BNE || BLT || BGE);
    BranchEn       = resolve;
    stall          = active && br_valid && !opnd_ready;
    flush          = in_redirect;
    redirect_valid = in_redirect;
  end

  // Next-state selection; a wrong-path br_valid in REDIRECT is ignored, unknown states fall to IDLE
  always_comb begin
    state_nxt = ST_IDLE;
    case (state)
      ST_IDLE, ST_WAIT: begin
        if (taken)
          state_nxt = ST_REDIRECT;
        else if (br_valid && !opnd_ready)
          state_nxt = ST_WAIT;
        else
          state_nxt = ST_IDLE;
      end
      ST_REDIRECT: state_nxt = ST_IDLE;
      default:     state_nxt = ST_IDLE;
    endcase
  end

  // State, branch target register and saturating statistics counters
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      redirect_pc <= '0;
      br_count    <= '0;
      taken_count <= '0;
    end else begin
      state <= state_nxt;
      if (taken)
        redirect_pc <= (pc_ex + imm_b) & ALIGN_MASK;
      if (resolve && (br_count != CNT_MAX))
        br_count <= br_count + CNT_ONE;
      if (taken && (taken_count != CNT_MAX))
        taken_count <= taken_count + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_branch_ctrl.sv
// Directed bench for branch_ctrl with a 4-bit counter build so saturation is reachable.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
// Expected values are hand-computed constants.
module tb_branch_ctrl;

  localparam int WIDTH = 32;
  localparam int CNT_W = 4;

  logic             clock;
  logic             reset;
  logic             br_valid;
  logic [2:0]       br_func3;
  logic             opnd_ready;
  logic [WIDTH-1:0] pc_ex;
  logic [WIDTH-1:0] imm_b;
  logic             BEQ, BNE, BLT, BGE;
  logic             BranchEn, stall, flush, redirect_valid;
  logic [WIDTH-1:0] redirect_pc;
  logic [CNT_W-1:0] br_count, taken_count;

  int n_checks = 0;
  int n_fails  = 0;

  branch_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clock(clock), .reset(reset), .br_valid(br_valid), .br_func3(br_func3),
    .opnd_ready(opnd_ready), .pc_ex(pc_ex), .imm_b(imm_b),
    .BEQ(BEQ), .BNE(BNE), .BLT(BLT), .BGE(BGE),
    .BranchEn(BranchEn), .stall(stall), .flush(flush),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .br_count(br_count), .taken_count(taken_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] f3, input logic rdy,
                       input logic [31:0] pc, input logic [31:0] imm,
                       input logic eq, input logic ne, input logic lt, input logic ge);
    br_valid = v; br_func3 = f3; opnd_ready = rdy; pc_ex = pc; imm_b = imm;
    BEQ = eq; BNE = ne; BLT = lt; BGE = ge;
  endtask

  task automatic idle();
    drive(1'b0, 3'b000, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic ctrl_chk(input string tag, input logic be, input logic st,
                          input logic fl, input logic rv);
    check_eq({tag, "_BranchEn"}, {31'b0, BranchEn}, {31'b0, be});
    check_eq({tag, "_stall"}, {31'b0, stall}, {31'b0, st});
    check_eq({tag, "_flush"}, {31'b0, flush}, {31'b0, fl});
    check_eq({tag, "_redirect_valid"}, {31'b0, redirect_valid}, {31'b0, rv});
  endtask

  task automatic cnt_chk(input string tag, input int bc, input int tc);
    check_eq({tag, "_br_count"}, {28'b0, br_count}, bc);
    check_eq({tag, "_taken_count"}, {28'b0, taken_count}, tc);
  endtask

  initial begin
    // Reset with a would-stall request on the inputs: everything must stay low
    reset = 1'b1;
    drive(1'b1, 3'b000, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clock);
    ctrl_chk("rst", 1'b0, 1'b0, 1'b0, 1'b0);
    check_eq("rst_redirect_pc", redirect_pc, 32'h0);
    cnt_chk("rst", 0, 0);
    tick();
    reset = 1'b0;

    // Taken BEQ resolving on the first edge after reset release
    drive(1'b1, 3'b000, 1'b1, 32'h100, 32'h20, 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clock);
    ctrl_chk("beq_res", 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    idle();
    @(negedge clock);
    ctrl_chk("beq_redir", 1'b0, 1'b0, 1'b1, 1'b1);
    check_eq("beq_redirect_pc", redirect_pc, 32'h120);
    cnt_chk("beq", 1, 1);
    tick();
    @(negedge clock);
    ctrl_chk("beq_after", 1'b0, 1'b0, 1'b0, 1'b0);
    check_eq("beq_pc_hold", redirect_pc, 32'h120);

    // Three stall cycles, then a not-taken BNE
    drive(1'b1, 3'b001, 1'b0, 32'h300, 32'h40, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      ctrl_chk($sformatf("bne_wait%0d", i), 1'b0, 1'b1, 1'b0, 1'b0);
      tick();
    end
    opnd_ready = 1'b1;
    @(negedge clock);
    ctrl_chk("bne_res", 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    idle();
    @(negedge clock);
    ctrl_chk("bne_after", 1'b0, 1'b0, 1'b0, 1'b0);
    cnt_chk("bne", 2, 1);
    check_eq("bne_pc_hold", redirect_pc, 32'h120);

    // Taken BLT followed by a wrong-path branch in the REDIRECT cycle
    tick();
    drive(1'b1, 3'b100, 1'b1, 32'h200, 32'hFFFF_FFF8, 1'b0, 1'b0, 1'b1, 1'b0);
    @(negedge clock);
    ctrl_chk("blt_res", 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    @(negedge clock);
    ctrl_chk("blt_wrongpath", 1'b0, 1'b0, 1'b1, 1'b1);
    check_eq("blt_redirect_pc", redirect_pc, 32'h1F8);
    cnt_chk("blt_redir", 3, 2);
    tick();
    idle();
    @(negedge clock);
    ctrl_chk("blt_after", 1'b0, 1'b0, 1'b0, 1'b0);
    cnt_chk("blt_after", 3, 2);

    // Target wraps past 2^32 and bit 0 is cleared
    tick();
    drive(1'b1, 3'b101, 1'b1, 32'hFFFF_FFF0, 32'h0000_0013, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    idle();
    @(negedge clock);
    check_eq("bge_wrap_pc", redirect_pc, 32'h2);
    ctrl_chk("bge_redir", 1'b0, 1'b0, 1'b1, 1'b1);
    cnt_chk("bge", 4, 3);

    // Unsupported func3 resolves not-taken but is counted
    tick();
    drive(1'b1, 3'b010, 1'b1, 32'h400, 32'h8, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clock);
    ctrl_chk("f3_010_res", 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    idle();
    @(negedge clock);
    ctrl_chk("f3_010_after", 1'b0, 1'b0, 1'b0, 1'b0);
    cnt_chk("f3_010", 5, 3);

    // Branch killed while waiting for operands
    tick();
    drive(1'b1, 3'b000, 1'b0, 32'h500, 32'h10, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clock);
    ctrl_chk("kill_wait", 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    idle();
    @(negedge clock);
    ctrl_chk("kill_drop", 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    @(negedge clock);
    ctrl_chk("kill_after", 1'b0, 1'b0, 1'b0, 1'b0);
    cnt_chk("kill", 5, 3);

    // Reset asserted while in WAIT
    drive(1'b1, 3'b000, 1'b0, 32'h600, 32'h10, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    reset = 1'b1;
    #1;
    ctrl_chk("rst_wait", 1'b0, 1'b0, 1'b0, 1'b0);
    cnt_chk("rst_wait", 0, 0);
    tick();
    reset = 1'b0;
    idle();
    @(negedge clock);
    ctrl_chk("rst_wait_rel", 1'b0, 1'b0, 1'b0, 1'b0);

    // Reset asserted while in REDIRECT
    tick();
    drive(1'b1, 3'b000, 1'b1, 32'h700, 32'h10, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    idle();
    reset = 1'b1;
    #1;
    ctrl_chk("rst_redir", 1'b0, 1'b0, 1'b0, 1'b0);
    check_eq("rst_redir_pc", redirect_pc, 32'h0);
    cnt_chk("rst_redir", 0, 0);
    tick();
    reset = 1'b0;
    // State must be IDLE: a ready branch resolves immediately
    drive(1'b1, 3'b000, 1'b1, 32'h800, 32'h10, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clock);
    ctrl_chk("rst_redir_rel", 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    idle();
    @(negedge clock);
    cnt_chk("post_rst", 1, 0);

    // Saturation of the 4-bit counters
    for (int i = 0; i < 20; i++) begin
      tick();
      drive(1'b1, 3'b000, 1'b1, 32'h1000, 32'h4, 1'b1, 1'b0, 1'b0, 1'b0);
      tick();
      idle();
      if (i == 13) begin
        @(negedge clock);
        cnt_chk("sat_mid", 15, 14);
      end
    end
    @(negedge clock);
    cnt_chk("sat_end", 15, 15);
    check_eq("sat_redirect_pc", redirect_pc, 32'h1004);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/branch_ctrl.md
BRANCH_CTRL -- requirements
Module: branch_ctrl

Interface
REQ-001 Parameter: WIDTH, default 32, datapath and PC width.
REQ-002 Parameter: CNT_W, default 16, width of the branch statistics counters.
REQ-003 Clock and reset: one clock; reset is asynchronous and active-high.
REQ-004 Port: clock  input  1  system clock; all state updates on the rising edge.
REQ-005 Port: reset  input  1  asynchronous, active-high; clears all state.
REQ-006 Port: br_valid  input  1  a conditional branch instruction occupies EX.
REQ-007 Port: br_func3  input  3  func3 field of the branch in EX.
REQ-008 Port: opnd_ready  input  1  forwarded operands a/b for the comparator are valid this cycle.
REQ-009 Port: pc_ex  input  WIDTH  PC of the branch in EX.
REQ-010 Port: imm_b  input  WIDTH  sign-extended B-type offset.
REQ-011 Port: BEQ, BNE, BLT, BGE  input  1 each  comparator results, gated by BranchEn.
REQ-012 Port: BranchEn  output  1  comparator enable.
REQ-013 Port: stall  output  1  holds PC, IF/ID and ID/EX registers.
REQ-014 Port: flush  output  1  kills the instructions in IF and ID.
REQ-015 Port: redirect_valid  output  1  load redirect_pc into the PC this cycle.
REQ-016 Port: redirect_pc  output  WIDTH  branch target.
REQ-017 Port: br_count, taken_count  output  CNT_W each  resolved and taken branch counters.

Function
REQ-018 States: IDLE, WAIT, REDIRECT; a registered state with a combinational output decode.
REQ-019 taken = BEQ | BNE | BLT | BGE, sampled only in a cycle with BranchEn=1.
REQ-020 BranchEn = 1 iff the state is IDLE or WAIT, br_valid=1 and opnd_ready=1 (the resolve cycle).
REQ-021 In IDLE with br_valid=1 and opnd_ready=0: stall=1 and next state WAIT.
REQ-022 In WAIT with opnd_ready=0: stall=1 and the FSM remains in WAIT indefinitely.
REQ-023 In WAIT with opnd_ready=1: the branch resolves this cycle and stall=0.
REQ-024 If br_valid drops to 0 while in WAIT (external kill), the FSM returns to IDLE with no count and no redirect.
REQ-025 On resolve with taken=1: register redirect_pc = (pc_ex + imm_b) mod 2^WIDTH with bit 0 forced to 0, and go to REDIRECT.
REQ-026 On resolve with taken=0: no redirect and the FSM stays in (or returns to) IDLE.
REQ-027 In REDIRECT, for exactly 1 cycle: redirect_valid=1, flush=1, stall=0, BranchEn=0; next state IDLE.
REQ-028 br_valid is ignored in REDIRECT, because that instruction is on the wrong path; no count and no resolve.
REQ-029 Redirect latency is exactly 1 cycle after the resolve cycle; back-to-back branches are separated by at least the REDIRECT cycle.
REQ-030 An unsupported br_func3 (010, 011, 110, 111) gives comparator outputs of 0; it resolves as not-taken and is counted in br_count.
REQ-031 br_count increments by 1 per resolve cycle, and taken_count by 1 per taken resolve.
REQ-032 Both counters saturate at all-ones and never wrap.
REQ-033 redirect_pc holds its last value outside REDIRECT; redirect_valid qualifies it.
REQ-034 Outputs stall, flush, BranchEn and redirect_valid are never asserted by X or by a state outside IDLE/WAIT/REDIRECT; an illegal state recovers to IDLE on the next clock.

Reset
REQ-035 While reset=1: state=IDLE, redirect_pc=0, br_count=0, taken_count=0, stall=0, flush=0, redirect_valid=0, BranchEn=0.
REQ-036 Reset asserted mid-WAIT or mid-REDIRECT aborts immediately (asynchronously): no redirect is issued and counts are cleared.
REQ-037 The first resolve can occur in the first rising edge after reset deasserts.

Verification
REQ-038 Taken BEQ: pc_ex=0x100, imm_b=0x20, br_func3=000, opnd_ready=1, BEQ=1 -> BranchEn=1 in cycle N; in cycle N+1 redirect_valid=1, flush=1, redirect_pc=0x120; br_count=1, taken_count=1.
REQ-039 Stall-then-resolve: br_valid=1 with opnd_ready=0 for 3 cycles, then 1 with BNE=0 -> stall=1 for 3 cycles, BranchEn=1 on the 4th, no redirect; br_count=1, taken_count=0.
REQ-040 Wrong-path suppression: taken BLT at cycle N, then br_valid=1 at N+1 -> the N+1 branch is ignored; br_count increments only once.
REQ-041 Wrap and alignment: pc_ex=0xFFFFFFF0, imm_b=0x00000013, BGE=1 -> redirect_pc=0x00000002.
REQ-042 Saturation: preload via 2^CNT_W+5 taken branches (or a reduced CNT_W=4 build) -> both counters remain 0xF..F.
REQ-043 Reset in WAIT and in REDIRECT -> all outputs 0 in the same cycle, and state IDLE after release.
